// File: rtl/edge_scan_controller.sv
// Raster-scan sequencer: builds a 5-pixel sliding window per row, drives a LATENCY-deep
// edge-detector pipeline and streams tagged results. Define EDGE_SCAN_STATS_EN to add edge_count.
module edge_scan_controller #(
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 48,
  parameter int LATENCY = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [23:0]  pix_data,
  output logic [119:0] win_pixels,
  output logic         pipe_en,
  input  logic         pipe_result,
  output logic         edge_valid,
  input  logic         edge_ready,
  output logic         edge_flag,
  output logic [15:0]  edge_col,
  output logic [15:0]  edge_row,
  output logic         busy,
  output logic         frame_done
`ifdef EDGE_SCAN_STATS_EN
  ,
  output logic [15:0]  edge_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] LAST_COL      = 16'(WIDTH - 1);
  localparam logic [15:0] LAST_ROW      = 16'(HEIGHT - 1);
  localparam logic [15:0] FIRST_WIN_COL = 16'd4;

  state_t             state_r;
  state_t             state_next_s;
  logic [15:0]        pix_col_r;
  logic [15:0]        pix_row_r;
  logic [2:0]         fill_r;
  logic [LATENCY-1:0] tags_r;
  logic [LATENCY-1:0] tags_next_s;
  logic [LATENCY:0]   tags_shift_s;
  logic               stall_s;
  logic               handshake_s;
  logic               accept_s;
  logic               last_pix_s;
  logic               tag_in_s;
  logic               tag_out_s;
  logic               load_s;
  logic               start_ok_s;
  logic               flush_empty_s;

  assign stall_s       = edge_valid && !edge_ready;
  assign handshake_s   = edge_valid && edge_ready;
  assign pix_ready     = (state_r == RUN) && !stall_s;
  assign accept_s      = pix_valid && pix_ready;
  assign last_pix_s    = (pix_col_r == LAST_COL) && (pix_row_r == LAST_ROW);
  assign tag_out_s     = tags_r[LATENCY-1];
  assign load_s        = pipe_en && tag_out_s;
  assign busy          = (state_r != IDLE);
  assign start_ok_s    = start && (state_r == IDLE);
  assign flush_empty_s = !(|tags_r);
  assign tags_shift_s  = {tags_r, tag_in_s};
  assign tags_next_s   = tags_shift_s[LATENCY-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, pipeline advance and tag injection
  always_comb begin
    state_next_s = state_r;
    pipe_en      = 1'b0;
    tag_in_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        // A window is complete once four earlier pixels of this row are already held.
        if (accept_s && (fill_r >= 3'd4)) begin
          pipe_en  = 1'b1;
          tag_in_s = 1'b1;
        end else begin
          pipe_en  = 1'b0;
          tag_in_s = 1'b0;
        end
        if (accept_s && last_pix_s) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH: begin
        if (!stall_s && !flush_empty_s) begin
          pipe_en = 1'b1;
        end else begin
          pipe_en = 1'b0;
        end
        if (flush_empty_s && (!edge_valid || edge_ready)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: begin
        state_next_s = IDLE;
        pipe_en      = 1'b0;
        tag_in_s     = 1'b0;
      end
    endcase
  end

  // Input raster position, per-row fill count and sliding window
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_col_r  <= 16'd0;
      pix_row_r  <= 16'd0;
      fill_r     <= 3'd0;
      win_pixels <= 120'd0;
    end else if (start_ok_s) begin
      pix_col_r  <= 16'd0;
      pix_row_r  <= 16'd0;
      fill_r     <= 3'd0;
      win_pixels <= win_pixels;
    end else if (accept_s) begin
      win_pixels <= {pix_data, win_pixels[119:24]};
      if (pix_col_r == LAST_COL) begin
        pix_col_r <= 16'd0;
        pix_row_r <= pix_row_r + 16'd1;
        fill_r    <= 3'd0;
      end else begin
        pix_col_r <= pix_col_r + 16'd1;
        pix_row_r <= pix_row_r;
        if (fill_r < 3'd5) begin
          fill_r <= fill_r + 3'd1;
        end else begin
          fill_r <= fill_r;
        end
      end
    end else begin
      pix_col_r  <= pix_col_r;
      pix_row_r  <= pix_row_r;
      fill_r     <= fill_r;
      win_pixels <= win_pixels;
    end
  end

  // Valid-tag shadow of the detector pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      tags_r <= {LATENCY{1'b0}};
    end else if (pipe_en) begin
      tags_r <= tags_next_s;
    end else begin
      tags_r <= tags_r;
    end
  end

  // Result register; a new load may coincide with the handshake of the previous result
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_valid <= 1'b0;
      edge_flag  <= 1'b0;
      edge_col   <= FIRST_WIN_COL;
      edge_row   <= 16'd0;
    end else begin
      if (load_s) begin
        edge_valid <= 1'b1;
        edge_flag  <= pipe_result;
      end else if (handshake_s) begin
        edge_valid <= 1'b0;
        edge_flag  <= edge_flag;
      end else begin
        edge_valid <= edge_valid;
        edge_flag  <= edge_flag;
      end
      if (start_ok_s) begin
        edge_col <= FIRST_WIN_COL;
        edge_row <= 16'd0;
      end else if (handshake_s) begin
        if (edge_col == LAST_COL) begin
          edge_col <= FIRST_WIN_COL;
          edge_row <= edge_row + 16'd1;
        end else begin
          edge_col <= edge_col + 16'd1;
          edge_row <= edge_row;
        end
      end else begin
        edge_col <= edge_col;
        edge_row <= edge_row;
      end
    end
  end

  // End-of-frame pulse, raised on the FLUSH to IDLE transition
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state_r == FLUSH) && (state_next_s == IDLE);
    end
  end

`ifdef EDGE_SCAN_STATS_EN
  // Saturating count of accepted results that flagged an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_count <= 16'd0;
    end else if (start_ok_s) begin
      edge_count <= 16'd0;
    end else if (handshake_s && edge_flag && (edge_count != 16'hFFFF)) begin
      edge_count <= edge_count + 16'd1;
    end else begin
      edge_count <= edge_count;
    end
  end
`endif

endmodule

// File: doc/edge_scan_controller.md
EDGE_SCAN_CONTROLLER -- requirements
Module: edge_scan_controller

Interface
REQ-001 Parameter WIDTH, default 64: pixels per row; legal range 5..65535.
REQ-002 Parameter HEIGHT, default 48: rows per frame; legal range 1..65535.
REQ-003 Parameter LATENCY, default 7: edge-detector pipeline depth in pipe_en advances; legal range 1..32.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-007 pix_valid  in  1  / pix_ready  out  1 / pix_data  in  24  raster-order pixel stream; transfer when valid && ready.
REQ-008 win_pixels  out  5x24 (120 bits)  sliding window to detector; slot 0 oldest, slot 4 newest.
REQ-009 pipe_en  out  1  advance strobe for every detector stage.
REQ-010 pipe_result  in  1  detector result stage output, sampled when pipe_en is high.
REQ-011 edge_valid  out  1  / edge_ready  in  1 / edge_flag  out  1  result stream; transfer when valid && ready.
REQ-012 edge_col, edge_row  out  16 each  coordinates of the current result.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 frame_done  out  1  one-cycle pulse after the last result of a frame is accepted.

Function
REQ-015 States: IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH when pixel WIDTH*HEIGHT is accepted; FLUSH->IDLE when the last result is accepted.
REQ-016 stall = edge_valid && !edge_ready; pix_ready = (state==RUN) && !stall.
REQ-017 Each accepted pixel shifts into win_pixels slot 4, and older pixels move down one slot.
REQ-018 Fill counter counts 0..5 per row and resets to 0 when column WIDTH-1 is accepted, so no window spans two rows.
REQ-019 When a pixel is accepted with fill count already 4 or greater, pipe_en is high in that cycle, with valid tag 1 entering the tag shift register.
REQ-020 Windows per row = WIDTH-4; results per frame = (WIDTH-4)*HEIGHT.
REQ-021 Tag shift register: LATENCY bits, advancing only on pipe_en.
REQ-022 When pipe_en is high and the tag leaving stage LATENCY is 1, the block registers pipe_result into edge_flag and sets edge_valid on the next cycle.
REQ-023 In FLUSH, pipe_en is high every cycle when !stall, inserting tag 0, until all tags are 0.
REQ-024 edge_valid holds until handshake, with edge_flag, edge_col and edge_row stable while stalled.
REQ-025 While stalled, pipe_en is low in all states; no result is dropped or duplicated.
REQ-026 edge_col starts at 4 and increments per accepted result, wrapping to 4 after WIDTH-1, at which point edge_row increments.
REQ-027 edge_row starts at 0.
REQ-028 start while busy is ignored.
REQ-029 pix_valid outside RUN is not accepted.
REQ-030 Simultaneous result handshake and new result in the same cycle: edge_valid stays high and the new data loads with no bubble.

Reset
REQ-031 Reset forces state IDLE and pix_ready=0, pipe_en=0, edge_valid=0, edge_flag=0, busy=0 and frame_done=0.
REQ-032 Reset clears edge_col to 4, edge_row to 0, the fill counter, all tags, and win_pixels to 0.
REQ-033 Reset mid-frame abandons the frame with no frame_done; the next frame requires a new start.

Configuration
REQ-034 With EDGE_SCAN_STATS_EN defined, the block adds output edge_count (16 bits), counting accepted results with edge_flag=1 and saturating at 65535.
REQ-035 edge_count clears on an honoured start and on reset, and holds its value in IDLE.
REQ-036 Without EDGE_SCAN_STATS_EN, the edge_count port and its logic are absent, and all other behaviour is identical.

Verification (WIDTH=8, HEIGHT=2, LATENCY=7)
REQ-037 Continuous pix_valid, edge_ready=1, pipe_result=1 -> 8 results, col sequence 4,5,6,7,4,5,6,7, rows 0,0,0,0,1,1,1,1, then one frame_done pulse, then IDLE.
REQ-038 First 4 pixels of each row -> pipe_en low; 5th pixel -> pipe_en high in the same cycle.
REQ-039 edge_ready held low for 10 cycles at the first result -> pix_ready=0 and pipe_en=0 throughout, the result held stable, and the total count still 8.
REQ-040 Reset asserted after pixel 10 -> all outputs at reset values next cycle, and no frame_done.
REQ-041 start pulsed during RUN -> no effect, with result count and coordinates unchanged.
REQ-042 With EDGE_SCAN_STATS_EN and pipe_result alternating 1,0 per advance -> edge_count=4 at frame_done.
